countdown_timer_pro: RTL and testbench

Parametrised second-resolution countdown timer for the traffic/FSM controllers. It adds pause/resume, an auto-reload (periodic) mode, a one-cycle expiry pulse alongside the sticky expired level, and generic clock-rate and count-width parameters. It sits between the control FSM (load/start/pause) and the display/blink logic, which consumes the 1 Hz / 2 Hz strobes and the live count.

---
 rtl/timer_pkg.sv | 19 +
 rtl/half_sec_prescaler.sv | 54 +++++
 rtl/countdown_timer_pro.sv | 125 ++++++++++++
 tb/tb_countdown_timer_pro.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and helpers for the countdown timer: FSM state encoding and
// prescaler width derived from the clock rate.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_e;

  // Bits needed to count 0..HALF-1; at least one bit so CLK_HZ=2 still works.
  function automatic int presc_width(input int clk_hz);
    int w;
    w = $clog2(clk_hz / 2);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/half_sec_prescaler.sv
// Half-second prescaler: counts enabled cycles and flags the cycle on which a
// half-second (and every second one, a full second) completes.
module half_sec_prescaler
  import timer_pkg::*;
#(
  parameter int CLK_HZ = 2000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic half_tick,
  output logic full_tick
);

  localparam int HALF = CLK_HZ / 2;
  localparam int PW = presc_width(CLK_HZ);
  localparam logic [PW-1:0] LAST = PW'(HALF - 1);

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic          phase_q, phase_d;
  logic          wrap;

  // Ticks are look-ahead flags: they are high on the edge where the wrap
  // happens so the parent can register its strobes and count on that edge.
  always_comb begin
    wrap        = enable && (prescaler_q == LAST);
    prescaler_d = prescaler_q;
    phase_d     = phase_q;
    if (clear) begin
      prescaler_d = '0;
      phase_d     = 1'b0;
    end else if (wrap) begin
      prescaler_d = '0;
      phase_d     = ~phase_q;
    end else if (enable) begin
      prescaler_d = prescaler_q + 1'b1;
    end
  end

  assign half_tick = wrap && !clear;
  assign full_tick = half_tick && phase_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      phase_q     <= phase_d;
    end
  end

endmodule

// File: rtl/countdown_timer_pro.sv
// Second-resolution countdown timer with pause, auto-reload, expiry pulse and
// 1 Hz / 2 Hz strobes for the display/blink logic.
module countdown_timer_pro
  import timer_pkg::*;
#(
  parameter int CLK_HZ = 2000,
  parameter int CNT_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] value,
  input  logic             start_timer,
  input  logic             pause,
  input  logic             auto_reload,
  output logic             expired,
  output logic             expired_pulse,
  output logic             one_hz_enable,
  output logic             two_hz_enable,
  output logic             busy,
  output logic [CNT_W-1:0] counter
);

  timer_state_e     state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0] reload_val_q, reload_val_d;
  logic             expired_q, expired_d;
  logic             expired_pulse_q, expired_pulse_d;
  logic             one_hz_q, one_hz_d;
  logic             two_hz_q, two_hz_d;
  logic             busy_q, busy_d;

  logic presc_enable;
  logic half_tick, full_tick;

  // The resume edge out of PAUSED counts, so a pause shifts events by exactly
  // the number of cycles pause was high.
  assign presc_enable = ((state_q == RUN) || (state_q == PAUSED)) && !pause && !start_timer;

  half_sec_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .clear    (start_timer),
    .enable   (presc_enable),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  always_comb begin
    state_d         = state_q;
    counter_d       = counter_q;
    reload_val_d    = reload_val_q;
    expired_pulse_d = 1'b0;
    one_hz_d        = 1'b0;
    two_hz_d        = 1'b0;

    if (start_timer) begin
      counter_d       = value;
      reload_val_d    = value;
      state_d         = (value != '0) ? RUN : EXPIRED;
      expired_pulse_d = (value == '0);
    end else begin
      case (state_q)
        RUN, PAUSED: begin
          if (pause) begin
            state_d = PAUSED;
          end else begin
            state_d  = RUN;
            two_hz_d = half_tick;
            one_hz_d = full_tick;
            // Expiry is the decrement from 1; zero is never decremented.
            if (full_tick && (counter_q != '0)) begin
              if (counter_q == CNT_W'(1)) begin
                expired_pulse_d = 1'b1;
                if (auto_reload) begin
                  counter_d = reload_val_q;
                end else begin
                  counter_d = '0;
                  state_d   = EXPIRED;
                end
              end else begin
                counter_d = counter_q - 1'b1;
              end
            end
          end
        end
        default: counter_d = '0;
      endcase
    end

    expired_d = (state_d == EXPIRED);
    busy_d    = (state_d == RUN) || (state_d == PAUSED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      counter_q       <= '0;
      reload_val_q    <= '0;
      expired_q       <= 1'b0;
      expired_pulse_q <= 1'b0;
      one_hz_q        <= 1'b0;
      two_hz_q        <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      counter_q       <= counter_d;
      reload_val_q    <= reload_val_d;
      expired_q       <= expired_d;
      expired_pulse_q <= expired_pulse_d;
      one_hz_q        <= one_hz_d;
      two_hz_q        <= two_hz_d;
      busy_q          <= busy_d;
    end
  end

  assign expired       = expired_q;
  assign expired_pulse = expired_pulse_q;
  assign one_hz_enable = one_hz_q;
  assign two_hz_enable = two_hz_q;
  assign busy          = busy_q;
  assign counter       = counter_q;

endmodule

// File: tb/tb_countdown_timer_pro.sv
// Self-checking bench for countdown_timer_pro: directed scenarios plus random
// traffic, all compared against an elapsed-cycle reference model.
module tb_countdown_timer_pro;

  localparam int CLK_HZ = 8;
  localparam int CNT_W  = 4;
  localparam int HALF   = CLK_HZ / 2;
  localparam int OW     = CNT_W + 5;

  logic             clock = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] value;
  logic             start_timer;
  logic             pause;
  logic             auto_reload;
  logic             expired;
  logic             expired_pulse;
  logic             one_hz_enable;
  logic             two_hz_enable;
  logic             busy;
  logic [CNT_W-1:0] counter;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: mode 0=idle 1=run 2=paused 3=expired; ticks counts
  // counting cycles since the last start.
  int m_mode   = 0;
  int m_ticks  = 0;
  int m_cnt    = 0;
  int m_reload = 0;
  bit m_pulse  = 1'b0;
  bit m_one    = 1'b0;
  bit m_two    = 1'b0;

  countdown_timer_pro #(
    .CLK_HZ(CLK_HZ),
    .CNT_W (CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .value        (value),
    .start_timer  (start_timer),
    .pause        (pause),
    .auto_reload  (auto_reload),
    .expired      (expired),
    .expired_pulse(expired_pulse),
    .one_hz_enable(one_hz_enable),
    .two_hz_enable(two_hz_enable),
    .busy         (busy),
    .counter      (counter)
  );

  always #5 clock = ~clock;

  function automatic void model_step();
    m_pulse = 1'b0;
    m_one   = 1'b0;
    m_two   = 1'b0;
    if (reset) begin
      m_mode = 0; m_ticks = 0; m_cnt = 0; m_reload = 0;
    end else if (start_timer) begin
      m_reload = int'(value);
      m_cnt    = int'(value);
      m_ticks  = 0;
      if (value == '0) begin
        m_mode  = 3;
        m_pulse = 1'b1;
      end else begin
        m_mode = 1;
      end
    end else if (m_mode == 1 || m_mode == 2) begin
      if (pause) begin
        m_mode = 2;
      end else begin
        m_mode  = 1;
        m_ticks = m_ticks + 1;
        m_two   = (m_ticks % HALF) == 0;
        m_one   = (m_ticks % (2 * HALF)) == 0;
        if (m_one) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_pulse = 1'b1;
            if (auto_reload) m_cnt = m_reload;
            else m_mode = 3;
          end
        end
      end
    end
  endfunction

  function automatic logic [OW-1:0] observed();
    return {expired, expired_pulse, one_hz_enable, two_hz_enable, busy, counter};
  endfunction

  function automatic logic [OW-1:0] expected();
    logic [CNT_W-1:0] c;
    c = CNT_W'(m_cnt);
    return {(m_mode == 3), m_pulse, m_one, m_two, (m_mode == 1 || m_mode == 2), c};
  endfunction

  // Applies the current inputs for one clock edge and settles past it.
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic start(input int v);
    value       = CNT_W'(v);
    start_timer = 1'b1;
    tick();
    start_timer = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      vectors++;
      if (observed() !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_idle k=%0d got=%b exp=%b", k, observed(), {OW{1'b0}});
      end
    end
  endtask

  task automatic test_oneshot();
    auto_reload = 1'b0;
    start(3);
    for (int k = 1; k <= 28; k++) begin
      tick();
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL oneshot k=%0d got=%b exp=%b", k, observed(), expected());
      end
      if (k == 4 || k == 8 || k == 16 || k == 24) begin
        vectors++;
        if (two_hz_enable !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL oneshot_two_hz k=%0d got=%b exp=1", k, two_hz_enable);
        end
      end
      if (k == 8 || k == 16) begin
        vectors++;
        if (counter !== CNT_W'(k == 8 ? 2 : 1)) begin
          miscompares++;
          $display("[TB] FAIL oneshot_count k=%0d got=%0d exp=%0d", k, counter, (k == 8 ? 2 : 1));
        end
      end
      if (k == 24) begin
        vectors++;
        if ({expired, expired_pulse, counter} !== {2'b11, CNT_W'(0)}) begin
          miscompares++;
          $display("[TB] FAIL oneshot_expire got=%b%b/%0d exp=11/0", expired, expired_pulse, counter);
        end
      end
      if (k == 25) begin
        vectors++;
        if ({expired, expired_pulse, busy} !== 3'b100) begin
          miscompares++;
          $display("[TB] FAIL oneshot_pulse_width got=%b exp=100", {expired, expired_pulse, busy});
        end
      end
    end
  endtask

  task automatic test_pause();
    auto_reload = 1'b0;
    start(3);
    for (int k = 1; k <= 36; k++) begin
      pause = (k >= 6 && k <= 15);
      tick();
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL pause k=%0d got=%b exp=%b", k, observed(), expected());
      end
      if (k == 17 || k == 18) begin
        vectors++;
        if ({one_hz_enable, counter} !== {(k == 18), CNT_W'(k == 18 ? 2 : 3)}) begin
          miscompares++;
          $display("[TB] FAIL pause_first_sec k=%0d got=%b/%0d", k, one_hz_enable, counter);
        end
      end
      if (k == 33 || k == 34) begin
        vectors++;
        if (expired !== (k == 34)) begin
          miscompares++;
          $display("[TB] FAIL pause_expire k=%0d got=%b exp=%b", k, expired, (k == 34));
        end
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_auto_reload();
    auto_reload = 1'b1;
    start(2);
    for (int k = 1; k <= 34; k++) begin
      tick();
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL reload k=%0d got=%b exp=%b", k, observed(), expected());
      end
      if (k % 8 == 0) begin
        vectors++;
        if ({expired_pulse, counter} !== {(k % 16 == 0), CNT_W'(k % 16 == 0 ? 2 : 1)}) begin
          miscompares++;
          $display("[TB] FAIL reload_seq k=%0d got=%b/%0d", k, expired_pulse, counter);
        end
      end
      vectors++;
      if ({busy, expired} !== 2'b10) begin
        miscompares++;
        $display("[TB] FAIL reload_busy k=%0d got=%b exp=10", k, {busy, expired});
      end
    end
    auto_reload = 1'b0;
  endtask

  task automatic test_zero_value();
    start(0);
    vectors++;
    if ({expired, expired_pulse, busy, counter} !== {3'b110, CNT_W'(0)}) begin
      miscompares++;
      $display("[TB] FAIL zero_start got=%b exp=110/0", {expired, expired_pulse, busy, counter});
    end
    pause = 1'b1;
    tick();
    pause = 1'b0;
    vectors++;
    if (observed() !== expected()) begin
      miscompares++;
      $display("[TB] FAIL zero_hold got=%b exp=%b", observed(), expected());
    end
    start(5);
    vectors++;
    if ({expired, busy, counter} !== {2'b01, CNT_W'(5)}) begin
      miscompares++;
      $display("[TB] FAIL restart_from_expired got=%b exp=01/5", {expired, busy, counter});
    end
  endtask

  task automatic test_max_value();
    auto_reload = 1'b0;
    start((1 << CNT_W) - 1);
    for (int k = 1; k <= 2 * HALF * ((1 << CNT_W) - 1) + 2; k++) begin
      tick();
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL max_value k=%0d got=%b exp=%b", k, observed(), expected());
      end
    end
  endtask

  task automatic test_reset_midrun();
    start(3);
    for (int k = 1; k <= 11; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (observed() !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_midrun got=%b exp=%b", observed(), {OW{1'b0}});
    end
  endtask

  task automatic test_start_with_pause();
    pause = 1'b1;
    start(3);
    vectors++;
    if ({busy, counter} !== {1'b1, CNT_W'(3)}) begin
      miscompares++;
      $display("[TB] FAIL start_pause_run got=%b/%0d exp=1/3", busy, counter);
    end
    for (int k = 1; k <= 10; k++) begin
      pause = (k <= 3);
      tick();
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL start_pause k=%0d got=%b exp=%b", k, observed(), expected());
      end
      if (k == 6 || k == 7) begin
        vectors++;
        if (two_hz_enable !== (k == 7)) begin
          miscompares++;
          $display("[TB] FAIL start_pause_shift k=%0d got=%b exp=%b", k, two_hz_enable, (k == 7));
        end
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      reset       = ($urandom_range(0, 149) == 0);
      start_timer = ($urandom_range(0, 29) == 0);
      value       = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 3));
      pause       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) auto_reload = ~auto_reload;
      tick();
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL random k=%0d got=%b exp=%b", k, observed(), expected());
      end
    end
    reset       = 1'b0;
    start_timer = 1'b0;
    pause       = 1'b0;
    auto_reload = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    value       = '0;
    start_timer = 1'b0;
    pause       = 1'b0;
    auto_reload = 1'b0;
    test_reset();
    test_oneshot();
    test_pause();
    test_auto_reload();
    test_zero_value();
    test_max_value();
    test_reset_midrun();
    test_start_with_pause();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
